// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   // X31 reads as zero, so a load targeting it can never feed a consumer.
   localparam int XZR       = 31;
   localparam int CNT_W_DEF = 16;

endpackage : pipe_ctrl_pkg

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by ID.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rm,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   output logic             lu_haz
);

   logic rd_is_zr;
   logic rn_match;
   logic rm_match;

   assign rd_is_zr = (ex_rd == REG_W'(XZR));
   assign rn_match = (ex_rd == id_rn);
   assign rm_match = id_uses_rm & (ex_rd == id_rm);
   assign lu_haz   = ex_memread & ~rd_is_zr & (rn_match | rm_match);

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: FSM, Mealy output decode and a
// saturating count of cycles in which the PC was held.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rm,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_branch_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_en,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t state_nxt;
   logic   lu_haz;
   logic   haz_eff;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .id_rn      (id_rn),
      .id_rm      (id_rm),
      .id_uses_rm (id_uses_rm),
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .lu_haz     (lu_haz)
   );

   // After a load-use stall EX holds the bubble, so the compare is stale.
   assign haz_eff = lu_haz & (state != LU_STALL);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output gets a default before any branch; a path that
   // leaves a variable unassigned in always_comb would infer a latch.
   always_comb begin
      state_nxt   = state;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_en     = 1'b0;

      if (reset) begin
         state_nxt = RUN;
      end else if (mem_busy) begin
         state_nxt = MEM_WAIT;
      end else if (haz_eff) begin
         idex_bubble = 1'b1;
         pipe_en     = 1'b1;
         state_nxt   = LU_STALL;
      end else begin
         // A branch coincident with a live hazard waits; it re-resolves here.
         pc_en      = 1'b1;
         ifid_en    = 1'b1;
         pipe_en    = 1'b1;
         ifid_flush = id_branch_taken;
         state_nxt  = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (!pc_en && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl, with a narrow-counter
// instance alongside for saturation.
module tb_pipe_hazard_ctrl;

   localparam int REG_W = 5;

   // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
   localparam logic [4:0] O_RUN   = 5'b11001;
   localparam logic [4:0] O_STALL = 5'b00011;
   localparam logic [4:0] O_FLUSH = 5'b11101;
   localparam logic [4:0] O_HOLD  = 5'b00000;

   logic             clk = 1'b0;
   logic             reset;
   logic [REG_W-1:0] id_rn, id_rm, ex_rd;
   logic             id_uses_rm, ex_memread, id_branch_taken, mem_busy;

   logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
   logic [15:0] stall_count;
   logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_en;
   logic [1:0]  s_stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rn           (id_rn),
      .id_rm           (id_rm),
      .id_uses_rm      (id_uses_rm),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .id_branch_taken (id_branch_taken),
      .mem_busy        (mem_busy),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .pipe_en         (pipe_en),
      .stall_count     (stall_count)
   );

   pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(2)) dut_sat (
      .clk             (clk),
      .reset           (reset),
      .id_rn           (id_rn),
      .id_rm           (id_rm),
      .id_uses_rm      (id_uses_rm),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .id_branch_taken (id_branch_taken),
      .mem_busy        (mem_busy),
      .pc_en           (s_pc_en),
      .ifid_en         (s_ifid_en),
      .ifid_flush      (s_ifid_flush),
      .idex_bubble     (s_idex_bubble),
      .pipe_en         (s_pipe_en),
      .stall_count     (s_stall_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return {27'd0, pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
   endfunction

   // Advance one edge, then let inputs be driven well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs are applied, given time to settle, then outputs are sampled.
   task automatic drive(input logic mr, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rn,
                        input logic [REG_W-1:0] rm, input logic urm, input logic br, input logic mb);
      ex_memread      = mr;
      ex_rd           = rd;
      id_rn           = rn;
      id_rm           = rm;
      id_uses_rm      = urm;
      id_branch_taken = br;
      mem_busy        = mb;
      #2;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check("reset_outs", outs(), {27'd0, O_HOLD});
      check("reset_cnt", 32'(stall_count), 32'd0);
      reset = 1'b0;
      drive(0, 1, 2, 6, 1, 0, 0);
      check("run_idle", outs(), {27'd0, O_RUN});
      tick();

      // Load-use on rn: one-cycle stall.
      drive(1, 3, 3, 0, 1, 0, 0);
      check("lu_rn_stall", outs(), {27'd0, O_STALL});
      tick();
      drive(0, 3, 3, 0, 1, 0, 0);
      check("lu_rn_resume", outs(), {27'd0, O_RUN});
      check("lu_rn_cnt", 32'(stall_count), 32'd1);
      tick();

      // Load-use on rm; hazard inputs left stale in LU_STALL must be masked.
      drive(1, 7, 2, 7, 1, 0, 0);
      check("lu_rm_stall", outs(), {27'd0, O_STALL});
      tick();
      check("lu_masked", outs(), {27'd0, O_RUN});
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("lu_rm_cnt", 32'(stall_count), 32'd2);

      // XZR and unused rm never stall.
      drive(1, 31, 31, 31, 1, 0, 0);
      check("xzr_no_stall", outs(), {27'd0, O_RUN});
      tick();
      drive(1, 5, 0, 5, 0, 0, 0);
      check("rm_unused", outs(), {27'd0, O_RUN});
      tick();

      // Taken branch flushes for one cycle.
      drive(0, 0, 0, 0, 0, 1, 0);
      check("branch_flush", outs(), {27'd0, O_FLUSH});
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("branch_done", outs(), {27'd0, O_RUN});
      tick();

      // Branch with hazard: stall wins, then the branch is honoured from LU_STALL.
      drive(1, 4, 4, 0, 0, 1, 0);
      check("br_haz_stall", outs(), {27'd0, O_STALL});
      tick();
      drive(0, 4, 4, 0, 0, 1, 0);
      check("br_after_stall", outs(), {27'd0, O_FLUSH});
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("br_haz_cnt", 32'(stall_count), 32'd3);
      tick();

      // mem_busy for 4 cycles: full hold, then normal flow on the 5th.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1);
         check($sformatf("mem_hold_%0d", i), outs(), {27'd0, O_HOLD});
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      check("mem_resume", outs(), {27'd0, O_RUN});
      check("mem_cnt", 32'(stall_count), 32'd7);
      tick();

      // mem_busy arriving during LU_STALL, resume as RUN.
      drive(1, 9, 9, 0, 0, 0, 0);
      check("lu_then_mem", outs(), {27'd0, O_STALL});
      tick();
      drive(1, 9, 9, 0, 0, 0, 1);
      check("lu_mem_hold", outs(), {27'd0, O_HOLD});
      tick();
      drive(0, 9, 9, 0, 0, 0, 0);
      check("lu_mem_resume", outs(), {27'd0, O_RUN});
      check("lu_mem_cnt", 32'(stall_count), 32'd9);
      tick();

      // MEM_WAIT exit evaluates the hazard like RUN.
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      drive(1, 12, 0, 12, 1, 1, 0);
      check("memwait_haz", outs(), {27'd0, O_STALL});
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("memwait_haz_done", outs(), {27'd0, O_RUN});
      check("memwait_cnt", 32'(stall_count), 32'd11);
      tick();

      // Saturation on the 2-bit counter.
      reset = 1'b1;
      tick();
      check("rst2_cnt", 32'(stall_count), 32'd0);
      check("rst2_sat_cnt", 32'(s_stall_count), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1);
         tick();
      end
      check("sat_cnt", 32'(s_stall_count), 32'd3);
      check("wide_cnt", 32'(stall_count), 32'd6);

      // Reset while in MEM_WAIT: outputs low, counts cleared, RUN afterwards.
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 0);
      check("rst_memwait_outs", outs(), {27'd0, O_HOLD});
      tick();
      check("rst_memwait_cnt", 32'(stall_count), 32'd0);
      check("rst_memwait_sat", 32'(s_stall_count), 32'd0);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      check("post_rst_run", outs(), {27'd0, O_RUN});
      tick();
      check("post_rst_cnt", 32'(stall_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipelined core. Each cycle it decides the enable, bubble and flush controls for the PC and the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all of which are built from enable flip-flops. It handles load-use stalls, taken-branch flushes and data-memory wait states, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_W, 5, register-number width
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rn  in  REG_W  first source register of the instruction in ID
- id_rm  in  REG_W  second source register of the instruction in ID
- id_uses_rm  in  1  instruction in ID reads id_rm
- ex_memread  in  1  instruction in EX is a load (LDUR)
- ex_rd  in  REG_W  destination register of the instruction in EX
- id_branch_taken  in  1  branch resolved taken in ID
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID at the next edge
- idex_bubble  out  1  load NOP control into ID/EX at the next edge
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB
- stall_count  out  CNT_W  cycles in which pc_en was 0, saturating

## Operation
- Hazard: `lu_haz = ex_memread & (ex_rd != 31) & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)))`. X31 (XZR) never causes a hazard.
- FSM states: RUN, LU_STALL, MEM_WAIT. All outputs are Mealy functions of state and inputs.
- Priority, highest first: reset, mem_busy, lu_haz, id_branch_taken.
- Any state with mem_busy=1:
  - pc_en = ifid_en = pipe_en = 0; ifid_flush = idex_bubble = 0.
  - Next state MEM_WAIT.
- RUN with lu_haz=1:
  - pc_en = 0, ifid_en = 0, idex_bubble = 1, pipe_en = 1, ifid_flush = 0.
  - Next state LU_STALL.
- RUN with id_branch_taken=1 and no hazard:
  - all enables 1, ifid_flush = 1.
  - Next state RUN.
- RUN otherwise: all enables 1, bubble and flush 0.
- LU_STALL with mem_busy=0:
  - lu_haz is masked, because EX now holds the bubble.
  - id_branch_taken is honoured as in RUN.
  - Next state RUN.
- MEM_WAIT with mem_busy=0: behaves exactly as RUN, including hazard and branch evaluation, and takes the RUN next state.
- lu_haz and id_branch_taken together: the stall wins and no flush is issued. The branch re-resolves on the next cycle, after the stall.
- stall_count increments by 1 each cycle pc_en=0 while reset=0, and saturates at 2^CNT_W-1.

## Timing
- While reset is high:
  - pc_en = ifid_en = pipe_en = ifid_flush = idex_bubble = 0.
  - state ← RUN and stall_count ← 0 at the edge.
- Outputs are valid combinationally in the same cycle as their inputs. Controlled registers act at the next rising edge.
- A load-use stall costs exactly 1 cycle: pc_en is low for one cycle per hazard.
- A mem_busy run of N cycles costs N cycles of full hold. No instruction is lost or duplicated.
- mem_busy asserted during LU_STALL: hold in MEM_WAIT, then resume as RUN. The hazard is not re-raised, because EX holds the bubble.
- Reset asserted mid-stall: the FSM returns to RUN at the next edge regardless of state.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum `{RUN, LU_STALL, MEM_WAIT}`;
  - the constant XZR = 31;
  - CNT_W default.
- Sub-module hazard_detect: purely combinational lu_haz compare.
- The top level holds the FSM, output decode and saturating counter.

## Test plan
- Load-use on rn:
  - Stimulus: ex_memread=1, ex_rd=3, id_rn=3; next cycle ex_memread=0.
  - Response: cycle 0 gives pc_en=0, ifid_en=0, idex_bubble=1; cycle 1 has all enables 1; stall_count=1.
- XZR / unused rm:
  - ex_rd=31 matching id_rn → no stall.
  - ex_rd=5, id_rm=5, id_uses_rm=0 → no stall.
- Taken branch:
  - id_branch_taken=1, no hazard → ifid_flush=1 for 1 cycle, pc_en=1.
  - Same together with a load-use hazard → stall first, flush 0 in that cycle.
- mem_busy for 4 cycles mid-stream:
  - all enables 0 for exactly 4 cycles;
  - stall_count +4;
  - normal flow resumes on the 5th cycle.
- Saturation and reset:
  - CNT_W=2, hold mem_busy for 6 cycles → stall_count sticks at 3.
  - Assert reset while in MEM_WAIT → outputs 0, count 0; RUN next cycle.
